// File: rtl/switch_port_arbiter.sv
// Packet-locked round-robin arbiter sharing one packetizer across NUM_PORTS ports.
// Define PKT_TIMEOUT_EN to abandon a locked packet after TIMEOUT_CYCLES idle cycles.
module switch_port_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int WIDTH_IN       = 142,
    parameter int ADDRESS_WIDTH  = 4,
    parameter int PORT_ID_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS*WIDTH_IN-1:0]     i_data_in,
    input  logic [NUM_PORTS-1:0]              i_valid_in,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] i_dest_in,
    output logic [NUM_PORTS-1:0]              i_ready_out,
    output logic [WIDTH_IN-1:0]               o_data_out,
    output logic [ADDRESS_WIDTH-1:0]          o_dest_out,
    output logic [PORT_ID_WIDTH-1:0]          o_src_port,
    output logic                              o_valid_out,
    input  logic                              o_ready_in,
    output logic                              o_proto_err,
    output logic                              o_timeout
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]               state;
    logic [PORT_ID_WIDTH-1:0] last_grant;
    logic [PORT_ID_WIDTH-1:0] lock_port;
    logic [PORT_ID_WIDTH-1:0] search_g;
    logic [PORT_ID_WIDTH-1:0] g;
    logic [PORT_ID_WIDTH-1:0] pidx;
    logic                     found;
    int                       idx;

    logic [WIDTH_IN-1:0]      words [NUM_PORTS];
    logic [ADDRESS_WIDTH-1:0] dests [NUM_PORTS];
    logic [WIDTH_IN-1:0]      word;
    logic                     valid_g;
    logic                     sop;
    logic                     pkt_end;
    logic                     can_load;
    logic                     discard;
    logic                     fire;
    logic                     load;
    logic                     to_hit;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            words[p] = i_data_in[p*WIDTH_IN +: WIDTH_IN];
            dests[p] = i_dest_in[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        end
    end

    // Round-robin search starting just after the previous owner
    always_comb begin
        search_g = '0;
        found    = 1'b0;
        idx      = 0;
        pidx     = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx  = (int'(last_grant) + k) % NUM_PORTS;
            pidx = PORT_ID_WIDTH'(idx);
            if (!found && i_valid_in[pidx]) begin
                found    = 1'b1;
                search_g = pidx;
            end
        end
    end

    assign g        = (state == LOCKED) ? lock_port : search_g;
    assign word     = words[g];
    assign valid_g  = i_valid_in[g];
    assign sop      = word[WIDTH_IN-2];
    assign pkt_end  = (word[WIDTH_IN-1] & word[WIDTH_IN-3]) |
                      (word[WIDTH_IN/2-1] & word[WIDTH_IN/2-3]);
    assign can_load = !o_valid_out | o_ready_in;
    assign discard  = (state == IDLE) & valid_g & !sop;

    always_comb begin
        i_ready_out = '0;
        if (valid_g && (discard || can_load)) begin
            i_ready_out[g] = 1'b1;
        end
    end

    assign fire = valid_g & i_ready_out[g];
    assign load = fire & !discard;

`ifdef PKT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] idle_cnt;

    assign to_hit = (state == LOCKED) & !valid_g &
                    (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Only cycles where the owning port itself is silent count
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt  <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= to_hit;
            if (state != LOCKED || fire || to_hit) begin
                idle_cnt <= '0;
            end else if (!valid_g) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
    assign to_hit    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= PORT_ID_WIDTH'(NUM_PORTS - 1);
            lock_port   <= '0;
            o_valid_out <= 1'b0;
            o_data_out  <= '0;
            o_dest_out  <= '0;
            o_src_port  <= '0;
            o_proto_err <= 1'b0;
        end else begin
            o_proto_err <= discard;
            if (load) begin
                o_valid_out <= 1'b1;
                o_data_out  <= word;
                o_dest_out  <= dests[g];
                o_src_port  <= g;
            end else if (can_load) begin
                o_valid_out <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (discard) begin
                        last_grant <= g;
                    end else if (load) begin
                        if (pkt_end) begin
                            last_grant <= g;
                        end else begin
                            state     <= LOCKED;
                            lock_port <= g;
                        end
                    end
                end
                LOCKED: begin
                    if ((load && pkt_end) || to_hit) begin
                        state      <= IDLE;
                        last_grant <= g;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/switch_port_arbiter.md
Name: switch_port_arbiter

Overview:
- Packet-locked round-robin arbiter that shares one switch packetizer between NUM_PORTS Ethernet-side input ports.
- Each port presents a 2-flit word. Per half: valid at top bit, then sop, then eop, then data.
- The block grants one port at a time. It holds the grant from the SOP word to the EOP word and registers the selected word, with its destination and source port, toward the packetizer input.

Parameters:
- NUM_PORTS, 4, number of requesting ports (2..16).
- WIDTH_IN, 142, width of one 2-flit word (even).
- ADDRESS_WIDTH, 4, destination router address width.
- PORT_ID_WIDTH, 2, width of source port index; must equal $clog2(NUM_PORTS).
- TIMEOUT_CYCLES, 256, stall limit; used only with PKT_TIMEOUT_EN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_data_in  input  NUM_PORTS*WIDTH_IN  port p word at [p*WIDTH_IN +: WIDTH_IN]
- i_valid_in  input  NUM_PORTS  per-port word valid
- i_dest_in  input  NUM_PORTS*ADDRESS_WIDTH  port p dest at [p*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- i_ready_out  output  NUM_PORTS  per-port accept
- o_data_out  output  WIDTH_IN  selected word, registered
- o_dest_out  output  ADDRESS_WIDTH  destination of selected word
- o_src_port  output  PORT_ID_WIDTH  index of granted port
- o_valid_out  output  1  output word valid
- o_ready_in  input  1  downstream (packetizer) ready
- o_proto_err  output  1  1-cycle pulse: non-SOP word discarded in IDLE
- o_timeout  output  1  1-cycle pulse: locked packet abandoned

Behaviour:
- Word field decode for port p:
  - sop = bit WIDTH_IN-2.
  - pkt_end = (bit WIDTH_IN-1 & bit WIDTH_IN-3) | (bit WIDTH_IN/2-1 & bit WIDTH_IN/2-3).
- Reset:
  - state = IDLE; last_grant = NUM_PORTS-1, so port 0 has first priority.
  - o_valid_out = 0; o_data_out, o_dest_out, o_src_port = 0.
  - o_proto_err = 0, o_timeout = 0; timeout counter = 0.
  - Reset mid-packet abandons the packet silently.
- Output register:
  - can_load = !o_valid_out | o_ready_in.
  - fire = i_valid_in[g] & i_ready_out[g].
  - On fire, the output register loads the word, dest and g, and o_valid_out = 1.
  - If can_load & !fire, o_valid_out = 0.
  - Otherwise the register holds: stable data under backpressure.
  - Latency from input fire to o_valid_out is 1 cycle. Full throughput of 1 word/cycle is sustained while o_ready_in = 1.
- i_ready_out:
  - Only bit g may be 1, and only when can_load.
  - In IDLE, bits of non-requesting ports are 0.
  - The one exception is the protocol-error discard below.
- State IDLE:
  - g is chosen combinationally: the first port p with i_valid_in[p], searched from last_grant+1 and wrapping modulo NUM_PORTS.
  - Candidate SOP word, fire this cycle:
    - pkt_end also set: single-word packet, stay IDLE, last_grant = g.
    - Else: go to LOCKED with g registered.
  - Candidate valid but sop = 0:
    - The word is discarded: the port's ready is 1 and the output register is not loaded.
    - o_proto_err pulses the next cycle.
    - last_grant = g, so the next search starts after the offender.
  - No requester: stay IDLE.
- State LOCKED:
  - g is fixed; other ports' ready = 0.
  - A word with pkt_end fires: go to IDLE and set last_grant = g.
  - A word with sop set while LOCKED passes through unchanged; the arbiter does not check it.
- Simultaneous events:
  - The end of one packet and a new request in the same cycle: the new port is granted on the next cycle, at the earliest.
  - One IDLE-grant cycle overlaps with that port's first word.

Optional Feature:
- Macro: PKT_TIMEOUT_EN.
- When defined:
  - In LOCKED, a counter increments every cycle where i_valid_in[g] = 0, and clears on fire.
  - When the counter reaches TIMEOUT_CYCLES-1 and the port is still idle:
    - Go to IDLE, set last_grant = g, clear the counter.
    - o_timeout pulses for 1 cycle.
  - Any data already in the output register completes normally. No EOP is synthesized.
  - Downstream stalls (o_ready_in = 0) do not count.
- When not defined: no counter logic; o_timeout tied 0; LOCKED waits indefinitely.

Test Plan:
- Single-word packets: reset, then ports 0..3 each present SOP+EOP continuously with o_ready_in = 1 -> o_src_port sequence 0,1,2,3,0,...; one word per cycle; first o_valid_out 1 cycle after the first fire.
- Packet lock: port 1 sends a 5-word packet (EOP on word 5) while port 2 requests continuously -> five consecutive outputs with o_src_port = 1, then port 2; i_ready_out[2] = 0 throughout.
- Backpressure: o_ready_in held 0 for 3 cycles mid-packet -> o_data_out stable and i_ready_out[g] = 0 during the hold; no word lost or duplicated.
- Protocol error: port 3 presents a valid non-SOP word in IDLE -> word discarded, o_proto_err = 1 for 1 cycle, next grant searches from port 0.
- Reset mid-packet: rst asserted during word 2 of a 4-word packet -> next cycle o_valid_out = 0 and state IDLE; port 0 is granted first.
- PKT_TIMEOUT_EN with TIMEOUT_CYCLES = 8: locked port 0 drops valid after word 1 -> o_timeout pulses after 8 idle cycles, then port 1 is granted; without the macro the grant stays on port 0 for 100 cycles.
